alu_request_arbiter: RTL
========================

Name: alu_request_arbiter

Overview:
- Shares one combinational ALU between NREQ requesters, e.g. the execute stage and the branch/address-generation path.
- Each requester uses a valid/ready request channel. The block arbitrates round-robin, drives the ALU operand/op inputs for the granted request, and captures the ALU result in a one-entry response register.
- Results return on a single response channel tagged with requester ID, one cycle after acceptance.

Parameters:
- XLEN, 32, data width of operands and result.
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID tag.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  NREQ  per-requester request valid.
- o_req_ready  out  NREQ  per-requester accept; one-hot or zero.
- i_req_op  in  NREQ*4  per-requester ALU opcode (core.svh Alu* encoding), requester k at bits [4k+3:4k].
- i_req_a  in  NREQ*XLEN  per-requester operand A.
- i_req_b  in  NREQ*XLEN  per-requester operand B.
- o_alu_rs1_rdata  out  XLEN  to ALU operand A.
- o_alu_rs2_rdata  out  XLEN  to ALU operand B.
- o_alu_imm  out  XLEN  tied to 0.
- o_alu_imm_sel  out  1  tied to 0.
- o_alu_op_data  out  4  to ALU opcode.
- i_alu_res_data  in  XLEN  ALU result.
- i_alu_res_zero  in  1  ALU zero flag.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumer ready.
- o_rsp_id  out  IDW  requester index of the response.
- o_rsp_data  out  XLEN  registered result.
- o_rsp_zero  out  1  registered zero flag.
- i_req_lock  in  NREQ  per-requester lock; present only with the optional feature.

Behaviour:
- Reset (synchronous, i_rst=1 at edge):
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_rsp_zero=0.
  - Round-robin pointer rr_ptr=0.
  - FSM=EMPTY.
  - o_req_ready is 0 during any cycle where i_rst=1.
- FSM, two states:
  - EMPTY: response register free.
  - FULL: o_rsp_valid=1, holding a result.
- can_accept = (FSM==EMPTY) | (i_rsp_ready & o_rsp_valid). This gives pass-through drain: full throughput of one op per cycle.
- Grant (combinational):
  - Scan requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first k with i_req_valid[k]=1 is granted, only if can_accept.
  - o_req_ready = one-hot(k) when granted, else 0.
- ALU drive:
  - o_alu_op_data/rs1/rs2 = granted requester's op/a/b.
  - With no grant: op=AluAdd, operands 0, so the ALU never sees an unsupported code.
- Handshake:
  - A request transfers when i_req_valid[k] & o_req_ready[k].
  - A requester must hold valid/op/a/b stable until accepted.
  - o_req_ready may depend combinationally on i_rsp_ready.
- On transfer at edge t:
  - o_rsp_data<=i_alu_res_data, o_rsp_zero<=i_alu_res_zero, o_rsp_id<=k.
  - FSM<=FULL; o_rsp_valid=1 from cycle t+1. Latency is exactly 1 cycle.
  - rr_ptr<=(k+1) mod NREQ.
- FULL & i_rsp_ready & no new transfer: FSM<=EMPTY, o_rsp_valid<=0. Data/id/zero hold their last values.
- FULL & ~i_rsp_ready:
  - Response outputs stable; no grant.
  - rr_ptr unchanged.
- No transfer: rr_ptr unchanged, so fairness is preserved across stalls.
- Reset mid-operation: the held response is discarded and not delivered. A requester whose request was not yet accepted must re-present it; it is not lost from the requester's side.
- Opcode legality is the requester's responsibility. The block passes codes through unchanged.

Optional Feature:
- Macro: ALU_REQUEST_ARBITER_LOCK_EN.
- Defined:
  - Adds input i_req_lock.
  - A transfer from k with i_req_lock[k]=1 sets lock_owner=k, lock_active=1, and rr_ptr stays at k.
  - While lock_active, only k may be granted.
  - The lock clears on the first transfer from k with i_req_lock[k]=0, or when i_req_valid[k]=0 for a cycle while can_accept.
  - Reset clears lock_active.
- Undefined: the i_req_lock port is absent; pure round-robin.

Test Plan:
- Single op: req0 valid, op=AluAdd, a=5, b=7, rsp_ready=1 -> ready[0]=1 cycle 0; cycle 1 o_rsp_valid=1, data=12, zero=0, id=0.
- Fairness: both valid continuously with AluSub, a=3, b=3, rsp_ready=1 -> grants alternate 0,1,0,1 each cycle; every response data=0, zero=1; ids alternate.
- Backpressure: accept req1 (AluXor 0xF0^0x0F), hold rsp_ready=0 for 3 cycles with req0 valid -> o_req_ready=0, data=0xFF stable with id=1; release -> req0 granted the same cycle, next response id=0.
- Reset mid-operation: FULL with data 0x55, assert i_rst one cycle -> next cycle o_rsp_valid=0, data=0, rr_ptr=0; req1-only valid then granted.
- Lock (macro on): req0 lock=1 for 3 ops while req1 valid -> 3 consecutive id=0 responses; lock=0 on 4th op -> next grant goes to req1.

Source files
------------

// File: rtl/alu_request_arbiter_if.sv
// Request, ALU-drive and response bundle for alu_request_arbiter.
// i_req_lock exists only when ALU_REQUEST_ARBITER_LOCK_EN is defined.
interface alu_request_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]           i_req_valid;
    logic [NREQ-1:0]           o_req_ready;
    logic [NREQ-1:0][3:0]      i_req_op;
    logic [NREQ-1:0][XLEN-1:0] i_req_a;
    logic [NREQ-1:0][XLEN-1:0] i_req_b;
`ifdef ALU_REQUEST_ARBITER_LOCK_EN
    logic [NREQ-1:0]           i_req_lock;
`endif
    logic [XLEN-1:0]           o_alu_rs1_rdata;
    logic [XLEN-1:0]           o_alu_rs2_rdata;
    logic [XLEN-1:0]           o_alu_imm;
    logic                      o_alu_imm_sel;
    logic [3:0]                o_alu_op_data;
    logic [XLEN-1:0]           i_alu_res_data;
    logic                      i_alu_res_zero;
    logic                      o_rsp_valid;
    logic                      i_rsp_ready;
    logic [IDW-1:0]            o_rsp_id;
    logic [XLEN-1:0]           o_rsp_data;
    logic                      o_rsp_zero;

    modport slave (
`ifdef ALU_REQUEST_ARBITER_LOCK_EN
        input  i_req_lock,
`endif
        input  i_req_valid, i_req_op, i_req_a, i_req_b,
        input  i_alu_res_data, i_alu_res_zero, i_rsp_ready,
        output o_req_ready, o_alu_rs1_rdata, o_alu_rs2_rdata, o_alu_imm,
        output o_alu_imm_sel, o_alu_op_data,
        output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_zero
    );

    modport master (
`ifdef ALU_REQUEST_ARBITER_LOCK_EN
        output i_req_lock,
`endif
        output i_req_valid, i_req_op, i_req_a, i_req_b,
        output i_alu_res_data, i_alu_res_zero, i_rsp_ready,
        input  o_req_ready, o_alu_rs1_rdata, o_alu_rs2_rdata, o_alu_imm,
        input  o_alu_imm_sel, o_alu_op_data,
        input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_zero
    );
endinterface

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters,
// with a one-entry response register. Optional grant lock: ALU_REQUEST_ARBITER_LOCK_EN.
module alu_request_arbiter_lane #(
    parameter int XLEN = 32
) (
    input  logic            gnt,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [3:0]      op_m,
    output logic [XLEN-1:0] a_m,
    output logic [XLEN-1:0] b_m
);
    assign op_m = op & {4{gnt}};
    assign a_m  = a & {XLEN{gnt}};
    assign b_m  = b & {XLEN{gnt}};
endmodule

module alu_request_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    alu_request_arbiter_if.slave bus
);
    localparam logic [3:0]   ALU_ADD = 4'd0;
    localparam logic [IDW:0] NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [NREQ-1:0] ONE  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e                    state_q, state_d;
    logic [IDW-1:0]            rr_ptr, gnt_idx, rr_nxt;
    logic [IDW:0]              off, sum, inc;
    logic [NREQ-1:0]           elig, rot, gnt_oh;
    logic                      found, can_accept, xfer, hold_ptr;
    logic [NREQ-1:0][3:0]      lane_op;
    logic [NREQ-1:0][XLEN-1:0] lane_a, lane_b;
    logic [3:0]                op_or;
    logic [XLEN-1:0]           a_or, b_or;
    logic [IDW-1:0]            rsp_id_q;
    logic [XLEN-1:0]           rsp_data_q;
    logic                      rsp_zero_q;

`ifdef ALU_REQUEST_ARBITER_LOCK_EN
    logic           lock_active;
    logic [IDW-1:0] lock_owner;

    assign elig     = lock_active ? (bus.i_req_valid & (ONE << lock_owner)) : bus.i_req_valid;
    assign hold_ptr = bus.i_req_lock[gnt_idx];

    // Owner going idle while the block could have taken its request ends the lock.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (xfer) begin
            lock_active <= bus.i_req_lock[gnt_idx];
            if (bus.i_req_lock[gnt_idx]) lock_owner <= gnt_idx;
        end else if (lock_active && can_accept && !bus.i_req_valid[lock_owner]) begin
            lock_active <= 1'b0;
        end
    end
`else
    assign elig     = bus.i_req_valid;
    assign hold_ptr = 1'b0;
`endif

    // Rotate so bit 0 is the requester at rr_ptr; first set bit is the winner.
    always_comb begin
        rot   = NREQ'({elig, elig} >> rr_ptr);
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = (IDW+1)'(i);
            end
        end
        sum     = {1'b0, rr_ptr} + off;
        gnt_idx = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : IDW'(sum);
        inc     = {1'b0, gnt_idx} + (IDW+1)'(1);
        rr_nxt  = (inc >= NREQ_W) ? '0 : IDW'(inc);
    end

    assign can_accept = (state_q == EMPTY) | (bus.i_rsp_ready & bus.o_rsp_valid);
    assign xfer       = found & can_accept & ~i_rst;
    assign gnt_oh     = xfer ? (ONE << gnt_idx) : '0;

    for (genvar k = 0; k < NREQ; k++) begin : g_lane
        alu_request_arbiter_lane #(.XLEN(XLEN)) u_lane (
            .gnt  (gnt_oh[k]),
            .op   (bus.i_req_op[k]),
            .a    (bus.i_req_a[k]),
            .b    (bus.i_req_b[k]),
            .op_m (lane_op[k]),
            .a_m  (lane_a[k]),
            .b_m  (lane_b[k])
        );
    end

    always_comb begin
        op_or = '0;
        a_or  = '0;
        b_or  = '0;
        for (int k = 0; k < NREQ; k++) begin
            op_or = op_or | lane_op[k];
            a_or  = a_or | lane_a[k];
            b_or  = b_or | lane_b[k];
        end
    end

    assign bus.o_req_ready     = gnt_oh;
    assign bus.o_alu_op_data   = xfer ? op_or : ALU_ADD;
    assign bus.o_alu_rs1_rdata = a_or;
    assign bus.o_alu_rs2_rdata = b_or;
    assign bus.o_alu_imm       = '0;
    assign bus.o_alu_imm_sel   = 1'b0;

    always_comb begin
        state_d = state_q;
        if (xfer)                                      state_d = FULL;
        else if (state_q == FULL && bus.i_rsp_ready)   state_d = EMPTY;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= EMPTY;
            rr_ptr     <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                rsp_id_q   <= gnt_idx;
                rsp_data_q <= bus.i_alu_res_data;
                rsp_zero_q <= bus.i_alu_res_zero;
                rr_ptr     <= hold_ptr ? gnt_idx : rr_nxt;
            end
        end
    end

    assign bus.o_rsp_valid = (state_q == FULL);
    assign bus.o_rsp_id    = rsp_id_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_zero  = rsp_zero_q;
endmodule
